pipe_ctrl_fsm: RTL and testbench

- Sequencing controller for the 5-stage pipeline. Produces the per-stage stall/flush controls that the forwarding logic leaves at zero.
- Schedules three hazard sources:
  - multi-cycle load-use bubbles;
  - data-memory (LSU) wait states, using a req/ack handshake with timeout;
  - taken-branch flushes.
- Also keeps stall/flush event counters for performance debug.

---
 rtl/pipe_ctrl_if.sv | 10 +
 rtl/pipe_ctrl_fsm.sv | 124 ++++++++++++
 tb/tb_pipe_ctrl_fsm.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// LSU handshake bundle between the pipeline controller (master) and the data-memory unit (slave).
interface pipe_ctrl_if;
  logic mem_req_M;
  logic lsu_ack;
  logic lsu_req;
  logic lsu_timeout;

  modport master (input mem_req_M, lsu_ack, output lsu_req, lsu_timeout);
  modport slave  (output mem_req_M, lsu_ack, input lsu_req, lsu_timeout);
endinterface

// File: rtl/pipe_ctrl_fsm.sv
// Pipeline sequencing controller: load-use bubbles, LSU wait/timeout, taken-branch flushes,
// plus stall/flush performance counters.
module pipe_ctrl_fsm #(
  parameter int LU_BUBBLES  = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_instr_D,
  input  logic [31:0]      i_instr_E,
  input  logic             i_rd_wren_E,
  input  logic             i_is_load_E,
  input  logic             i_br_taken_E,
  pipe_ctrl_if.master      lsu,
  output logic             o_StallF,
  output logic             o_StallD,
  output logic             o_StallE,
  output logic             o_StallM,
  output logic             o_StallW,
  output logic             o_FlushD,
  output logic             o_FlushE,
  output logic             o_FlushM,
  output logic             o_FlushW,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);
  localparam int BW = 2;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, MEM_ABORT} state_t;

  state_t         r_state, w_state_nx;
  logic [BW-1:0]  r_bcnt, w_bcnt_nx;
  logic [WW-1:0]  r_wcnt, w_wcnt_nx;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic           w_lu, w_mw, w_flush_inc;
  logic [4:0]     w_rs1_D, w_rs2_D, w_rd_E;
  logic           w_unused;

  assign w_rs1_D  = i_instr_D[19:15];
  assign w_rs2_D  = i_instr_D[24:20];
  assign w_rd_E   = i_instr_E[11:7];
  assign w_unused = ^{i_instr_D[31:25], i_instr_D[14:0], i_instr_E[31:12], i_instr_E[6:0]};

  assign w_lu = i_is_load_E & i_rd_wren_E & (w_rd_E != 5'd0) &
                ((w_rd_E == w_rs1_D) | (w_rd_E == w_rs2_D));
  assign w_mw = lsu.mem_req_M & ~lsu.lsu_ack;

  assign o_StallW    = 1'b0;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

  always_comb begin
    w_state_nx      = r_state;
    w_bcnt_nx       = r_bcnt;
    w_wcnt_nx       = r_wcnt;
    w_flush_inc     = 1'b0;
    lsu.lsu_req     = 1'b0;
    lsu.lsu_timeout = 1'b0;
    o_StallF = 1'b0; o_StallD = 1'b0; o_StallE = 1'b0; o_StallM = 1'b0;
    o_FlushD = 1'b0; o_FlushE = 1'b0; o_FlushM = 1'b0; o_FlushW = 1'b0;
    if (!i_reset) begin
      case (r_state)
        RUN, LU_STALL: begin
          lsu.lsu_req = lsu.mem_req_M;
          if (w_mw) begin
            // Memory wins; any remaining load-use bubbles are dropped.
            o_StallF = 1'b1; o_StallD = 1'b1; o_StallE = 1'b1; o_StallM = 1'b1;
            o_FlushW = 1'b1;
            w_wcnt_nx  = WW'(1);
            w_state_nx = MEM_WAIT;
          end else if (r_state == LU_STALL) begin
            o_StallF = 1'b1; o_StallD = 1'b1; o_FlushE = 1'b1;
            w_bcnt_nx = r_bcnt - BW'(1);
            if (r_bcnt == BW'(1)) w_state_nx = RUN;
          end else if (i_br_taken_E) begin
            o_FlushD    = 1'b1;
            o_FlushE    = 1'b1;
            w_flush_inc = 1'b1;
          end else if (w_lu) begin
            o_StallF = 1'b1; o_StallD = 1'b1; o_FlushE = 1'b1;
            w_bcnt_nx = BW'(LU_BUBBLES - 1);
            if (LU_BUBBLES > 1) w_state_nx = LU_STALL;
          end
        end
        MEM_WAIT: begin
          lsu.lsu_req = 1'b1;
          if (lsu.lsu_ack) begin
            w_state_nx = RUN;
          end else begin
            o_StallF = 1'b1; o_StallD = 1'b1; o_StallE = 1'b1; o_StallM = 1'b1;
            o_FlushW = 1'b1;
            w_wcnt_nx = r_wcnt + WW'(1);
            // wcnt_nx counts unacked cycles including this one
            if (w_wcnt_nx == WW'(MEM_TIMEOUT)) w_state_nx = MEM_ABORT;
          end
        end
        MEM_ABORT: begin
          lsu.lsu_timeout = 1'b1;
          o_FlushM        = 1'b1;
          w_state_nx      = RUN;
        end
        default: w_state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= RUN;
      r_bcnt      <= '0;
      r_wcnt      <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      r_bcnt  <= w_bcnt_nx;
      r_wcnt  <= w_wcnt_nx;
      if (o_StallF)    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Directed bench for pipe_ctrl_fsm: driver pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_pipe_ctrl_fsm;
  localparam logic [10:0] Z   = 11'h000;
  localparam logic [10:0] LU  = 11'h184;  // StallF StallD FlushE
  localparam logic [10:0] MW  = 11'h5E1;  // req StallF..M FlushW
  localparam logic [10:0] ACK = 11'h400;  // req only
  localparam logic [10:0] ABT = 11'h202;  // timeout FlushM
  localparam logic [10:0] BR  = 11'h00C;  // FlushD FlushE
  localparam logic [31:0] SKIP = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct {
    logic [10:0] out;
    logic [31:0] sc;
    logic [31:0] fc;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_D = NOP, instr_E = NOP;
  logic        wren = 1'b0, ld = 1'b0, br = 1'b0;
  logic        StallF, StallD, StallE, StallM, StallW;
  logic        FlushD, FlushE, FlushM, FlushW;
  logic [31:0] stall_cnt, flush_cnt;
  exp_t        exp_q[$];
  int          checks = 0, errors = 0, vec_id = 0;

  pipe_ctrl_if lsu_if();

  pipe_ctrl_fsm #(.LU_BUBBLES(2), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_instr_D(instr_D), .i_instr_E(instr_E),
    .i_rd_wren_E(wren), .i_is_load_E(ld), .i_br_taken_E(br), .lsu(lsu_if.master),
    .o_StallF(StallF), .o_StallD(StallD), .o_StallE(StallE), .o_StallM(StallM),
    .o_StallW(StallW), .o_FlushD(FlushD), .o_FlushE(FlushE), .o_FlushM(FlushM),
    .o_FlushW(FlushW), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mkD(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, 5'd6, 7'h33};
  endfunction

  function automatic logic [31:0] mkE(input logic [4:0] rd);
    return {17'd0, 3'b010, rd, 7'h03};
  endfunction

  task automatic step(input logic r, input logic [31:0] d, input logic [31:0] e,
                      input logic w, input logic l, input logic b, input logic mreq,
                      input logic ack, input logic [10:0] xo, input logic [31:0] xs,
                      input logic [31:0] xf);
    exp_t x;
    @(posedge clk); #1;
    rst = r; instr_D = d; instr_E = e; wren = w; ld = l; br = b;
    lsu_if.mem_req_M = mreq; lsu_if.lsu_ack = ack;
    x.out = xo; x.sc = xs; x.fc = xf; x.id = vec_id;
    exp_q.push_back(x);
    vec_id++;
  endtask

  task automatic idle(input logic [10:0] xo, input logic [31:0] xs, input logic [31:0] xf);
    step(0, NOP, NOP, 0, 0, 0, 0, 0, xo, xs, xf);
  endtask

  task automatic mem(input logic ack, input logic b, input logic [10:0] xo,
                     input logic [31:0] xs, input logic [31:0] xf);
    step(0, NOP, NOP, 0, 0, b, 1, ack, xo, xs, xf);
  endtask

  task automatic do_reset();
    step(1, NOP, NOP, 0, 0, 0, 0, 0, Z, SKIP, SKIP);
    step(1, NOP, NOP, 0, 0, 0, 0, 0, Z, 32'd0, 32'd0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      logic [10:0] act;
      x = exp_q.pop_front();
      act = {lsu_if.lsu_req, lsu_if.lsu_timeout, StallF, StallD, StallE, StallM, StallW,
             FlushD, FlushE, FlushM, FlushW};
      checks++;
      if (act !== x.out) begin
        errors++;
        $display("FAIL vec%0d outputs got %h want %h", x.id, act, x.out);
      end
      if (x.sc != SKIP) begin
        checks++;
        if (stall_cnt !== x.sc) begin
          errors++;
          $display("FAIL vec%0d stall_cnt got %0d want %0d", x.id, stall_cnt, x.sc);
        end
        checks++;
        if (flush_cnt !== x.fc) begin
          errors++;
          $display("FAIL vec%0d flush_cnt got %0d want %0d", x.id, flush_cnt, x.fc);
        end
      end
    end
  end

  initial begin
    lsu_if.mem_req_M = 1'b0;
    lsu_if.lsu_ack   = 1'b0;

    // load-use: lw x5 / add x6,x5,x1 -> two bubbles
    do_reset();
    step(0, mkD(5'd5, 5'd1), mkE(5'd5), 1, 1, 0, 0, 0, LU, 0, 0);
    idle(LU, 1, 0);
    idle(Z, 2, 0);
    // rd = x0 never stalls
    step(0, mkD(5'd0, 5'd1), mkE(5'd0), 1, 1, 0, 0, 0, Z, 2, 0);
    // match on rs2
    step(0, mkD(5'd1, 5'd7), mkE(5'd7), 1, 1, 0, 0, 0, LU, 2, 0);
    idle(LU, 3, 0);
    idle(Z, 4, 0);
    // register match but not a load
    step(0, mkD(5'd5, 5'd1), mkE(5'd5), 1, 0, 0, 0, 0, Z, 4, 0);
    // memory wait arriving during bubbles takes over
    step(0, mkD(5'd5, 5'd1), mkE(5'd5), 1, 1, 0, 0, 0, LU, 4, 0);
    mem(0, 0, MW, 5, 0);
    mem(1, 0, ACK, 6, 0);
    idle(Z, 6, 0);

    // LSU wait, ack on the 4th cycle, then zero-wait access
    do_reset();
    mem(0, 0, MW, 0, 0);
    mem(0, 0, MW, 1, 0);
    mem(0, 0, MW, 2, 0);
    mem(1, 0, ACK, 3, 0);
    idle(Z, 3, 0);
    mem(1, 0, ACK, 3, 0);
    idle(Z, 3, 0);

    // timeout after 4 unacked cycles
    do_reset();
    mem(0, 0, MW, 0, 0);
    mem(0, 0, MW, 1, 0);
    mem(0, 0, MW, 2, 0);
    mem(0, 0, MW, 3, 0);
    idle(ABT, 4, 0);
    idle(Z, 4, 0);

    // branch squashes concurrent load-use
    do_reset();
    step(0, mkD(5'd5, 5'd1), mkE(5'd5), 1, 1, 1, 0, 0, BR, 0, 0);
    idle(Z, 0, 1);

    // branch held during a 3-cycle memory wait
    do_reset();
    mem(0, 1, MW, 0, 0);
    mem(0, 1, MW, 1, 0);
    mem(0, 1, MW, 2, 0);
    mem(1, 1, ACK, 3, 0);
    step(0, NOP, NOP, 0, 0, 1, 0, 0, BR, 3, 0);
    idle(Z, 3, 1);

    // reset during the 2nd wait cycle, then a fresh request times out on schedule
    mem(0, 0, MW, 3, 1);
    step(1, NOP, NOP, 0, 0, 0, 1, 0, Z, 4, 1);
    idle(Z, 0, 0);
    mem(0, 0, MW, 0, 0);
    mem(0, 0, MW, 1, 0);
    mem(0, 0, MW, 2, 0);
    mem(0, 0, MW, 3, 0);
    idle(ABT, 4, 0);
    idle(Z, 4, 0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
